// File: rtl/irq_sequencer.sv
// Fixed-priority interrupt sequencer: latches level requests, masks with mie,
// issues a one-cycle trap pulse and acknowledges the serviced line after mret.
module irq_sequencer #(
  parameter int N_IRQ = 16
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic [N_IRQ-1:0] irq_req_i,
  input  logic [31:0]      mie_i,
  input  logic             stall_i,
  input  logic             mret_i,
  output logic             irq_o,
  output logic [31:0]      mcause_o,
  output logic [N_IRQ-1:0] irq_ret_o,
  output logic             busy_o
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_TRAP    = 2'd1,
    ST_SERVICE = 2'd2,
    ST_RETURN  = 2'd3
  } st_t;

  st_t              st_reg, st_next;
  logic [N_IRQ-1:0] pend_reg, pend_next;
  logic [3:0]       id_reg, id_next;
  logic [31:0]      mcause_reg, mcause_next;
  logic [N_IRQ-1:0] elig;
  logic [N_IRQ-1:0] clr;
  logic [3:0]       win_id;

  // Only mie[16 +: N_IRQ] matter; the rest are folded here so nothing dangles.
  logic unused_mie;
  assign unused_mie = ^mie_i;

  assign elig = pend_reg & mie_i[16 +: N_IRQ];

  // Acknowledge/clear one-hot, decoded from registered state only.
  genvar gi;
  generate
    for (gi = 0; gi < N_IRQ; gi++) begin : g_clr
      assign clr[gi] = (st_reg == ST_RETURN) && (id_reg == 4'(gi));
    end
  endgenerate

  // Lowest index wins: scan downwards so the last hit is the smallest index.
  always_comb begin
    win_id = 4'd0;
    for (int k = N_IRQ - 1; k >= 0; k--) begin
      if (elig[k]) win_id = 4'(k);
    end
  end

  always_comb begin
    st_next     = st_reg;
    id_next     = id_reg;
    mcause_next = mcause_reg;
    pend_next   = (pend_reg | irq_req_i) & ~clr;
    irq_o       = 1'b0;
    irq_ret_o   = '0;
    busy_o      = (st_reg != ST_IDLE);
    mcause_o    = mcause_reg;
    case (st_reg)
      ST_IDLE: begin
        if (|elig && !stall_i) begin
          id_next     = win_id;
          mcause_next = 32'h8000_0010 + 32'(win_id);
          st_next     = ST_TRAP;
        end
      end
      ST_TRAP: begin
        irq_o   = 1'b1;
        st_next = ST_SERVICE;
      end
      ST_SERVICE: begin
        if (mret_i) st_next = ST_RETURN;
      end
      ST_RETURN: begin
        irq_ret_o = clr;
        st_next   = ST_IDLE;
      end
      default: st_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      st_reg     <= ST_IDLE;
      pend_reg   <= '0;
      id_reg     <= 4'd0;
      mcause_reg <= 32'd0;
    end else begin
      st_reg     <= st_next;
      pend_reg   <= pend_next;
      id_reg     <= id_next;
      mcause_reg <= mcause_next;
    end
  end

endmodule

// File: tb/tb_irq_sequencer.sv
// Bench for irq_sequencer: per-cycle vector table plus a randomised stall
// sequence; each row's expected outputs are queued and checked after the edge.
module tb_irq_sequencer;

  logic        clk_i = 1'b0;
  logic        rstn_i = 1'b0;
  logic [15:0] irq_req_i = '0;
  logic [31:0] mie_i = '0;
  logic        stall_i = 1'b0;
  logic        mret_i = 1'b0;
  logic        irq_o;
  logic [31:0] mcause_o;
  logic [15:0] irq_ret_o;
  logic        busy_o;

  irq_sequencer #(.N_IRQ(16)) dut (
    .clk_i     (clk_i),
    .rstn_i    (rstn_i),
    .irq_req_i (irq_req_i),
    .mie_i     (mie_i),
    .stall_i   (stall_i),
    .mret_i    (mret_i),
    .irq_o     (irq_o),
    .mcause_o  (mcause_o),
    .irq_ret_o (irq_ret_o),
    .busy_o    (busy_o)
  );

  always #5 clk_i = ~clk_i;

  // One row = inputs for one cycle + outputs required after that cycle's edge.
  typedef struct {
    logic        rstn;
    logic [15:0] req;
    logic [31:0] mie;
    logic        stall;
    logic        mret;
    logic        irq;
    logic [31:0] mcause;
    logic [15:0] ret;
    logic        busy;
  } vec_t;

  typedef struct {
    int          idx;
    logic        irq;
    logic [31:0] mcause;
    logic [15:0] ret;
    logic        busy;
  } exp_t;

  vec_t tbl[$];
  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   row     = 0;

  function automatic vec_t mk(logic rstn, logic [15:0] req, logic [31:0] mie,
                              logic stall, logic mret, logic irq,
                              logic [31:0] mc, logic [15:0] ret, logic busy);
    vec_t v;
    v.rstn = rstn; v.req = req; v.mie = mie; v.stall = stall; v.mret = mret;
    v.irq = irq; v.mcause = mc; v.ret = ret; v.busy = busy;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    exp_t e;
    exp_t got;
    @(negedge clk_i);
    rstn_i = v.rstn; irq_req_i = v.req; mie_i = v.mie;
    stall_i = v.stall; mret_i = v.mret;
    e.idx = row; e.irq = v.irq; e.mcause = v.mcause; e.ret = v.ret; e.busy = v.busy;
    exp_q.push_back(e);
    @(posedge clk_i);
    #1;
    got = exp_q.pop_front();
    $display("[TB] row %0d rstn=%b req=%h stall=%b mret=%b -> irq=%b mcause=%h ret=%h busy=%b",
             got.idx, v.rstn, v.req, v.stall, v.mret, irq_o, mcause_o, irq_ret_o, busy_o);
    n_tests++;
    if (irq_o !== got.irq) begin
      n_fail++;
      $display("FAIL row %0d irq_o: got %b want %b", got.idx, irq_o, got.irq);
    end
    n_tests++;
    if (mcause_o !== got.mcause) begin
      n_fail++;
      $display("FAIL row %0d mcause_o: got %h want %h", got.idx, mcause_o, got.mcause);
    end
    n_tests++;
    if (irq_ret_o !== got.ret) begin
      n_fail++;
      $display("FAIL row %0d irq_ret_o: got %h want %h", got.idx, irq_ret_o, got.ret);
    end
    n_tests++;
    if (busy_o !== got.busy) begin
      n_fail++;
      $display("FAIL row %0d busy_o: got %b want %b", got.idx, busy_o, got.busy);
    end
    row++;
  endtask

  localparam logic [31:0] ALL = 32'hFFFF_0000;

  initial begin
    // Reset with all lines requesting, release, trap two cycles later.
    tbl.push_back(mk(0, 16'hFFFF, ALL, 0, 0, 0, 32'h0, 16'h0, 0));
    tbl.push_back(mk(0, 16'hFFFF, ALL, 0, 0, 0, 32'h0, 16'h0, 0));
    tbl.push_back(mk(1, 16'hFFFF, ALL, 0, 0, 0, 32'h0, 16'h0, 0));
    tbl.push_back(mk(1, 16'hFFFF, ALL, 0, 0, 1, 32'h8000_0010, 16'h0, 1));
    tbl.push_back(mk(1, 16'h0000, ALL, 0, 0, 0, 32'h8000_0010, 16'h0, 1));
    tbl.push_back(mk(1, 16'h0000, ALL, 0, 1, 0, 32'h8000_0010, 16'h0001, 1));
    tbl.push_back(mk(1, 16'h0000, ALL, 0, 0, 0, 32'h8000_0010, 16'h0, 0));
    tbl.push_back(mk(1, 16'h0000, ALL, 0, 0, 1, 32'h8000_0011, 16'h0, 1));
    tbl.push_back(mk(1, 16'h0000, ALL, 0, 0, 0, 32'h8000_0011, 16'h0, 1));
    // Reset in SERVICE: no ack, pend wiped so nothing re-traps.
    tbl.push_back(mk(0, 16'h0000, ALL, 0, 0, 0, 32'h0, 16'h0, 0));
    tbl.push_back(mk(1, 16'h0000, ALL, 0, 0, 0, 32'h0, 16'h0, 0));
    tbl.push_back(mk(1, 16'h0000, ALL, 0, 0, 0, 32'h0, 16'h0, 0));
    // Spurious mret in IDLE, then single interrupt on line 0.
    tbl.push_back(mk(1, 16'h0000, 32'h0001_0000, 0, 1, 0, 32'h0, 16'h0, 0));
    tbl.push_back(mk(1, 16'h0001, 32'h0001_0000, 0, 0, 0, 32'h0, 16'h0, 0));
    tbl.push_back(mk(1, 16'h0001, 32'h0001_0000, 0, 0, 1, 32'h8000_0010, 16'h0, 1));
    tbl.push_back(mk(1, 16'h0001, 32'h0001_0000, 0, 0, 0, 32'h8000_0010, 16'h0, 1));
    tbl.push_back(mk(1, 16'h0001, 32'h0001_0000, 0, 0, 0, 32'h8000_0010, 16'h0, 1));
    tbl.push_back(mk(1, 16'h0001, 32'h0001_0000, 0, 1, 0, 32'h8000_0010, 16'h0001, 1));
    tbl.push_back(mk(1, 16'h0000, 32'h0001_0000, 0, 0, 0, 32'h8000_0010, 16'h0, 0));
    tbl.push_back(mk(1, 16'h0000, 32'h0001_0000, 0, 0, 0, 32'h8000_0010, 16'h0, 0));
    // Priority: lines 2 and 5, line 2 first.
    tbl.push_back(mk(1, 16'h0024, 32'h0024_0000, 0, 0, 0, 32'h8000_0010, 16'h0, 0));
    tbl.push_back(mk(1, 16'h0024, 32'h0024_0000, 0, 0, 1, 32'h8000_0012, 16'h0, 1));
    tbl.push_back(mk(1, 16'h0024, 32'h0024_0000, 0, 0, 0, 32'h8000_0012, 16'h0, 1));
    tbl.push_back(mk(1, 16'h0020, 32'h0024_0000, 0, 1, 0, 32'h8000_0012, 16'h0004, 1));
    tbl.push_back(mk(1, 16'h0020, 32'h0024_0000, 0, 0, 0, 32'h8000_0012, 16'h0, 0));
    tbl.push_back(mk(1, 16'h0020, 32'h0024_0000, 0, 0, 1, 32'h8000_0015, 16'h0, 1));
    tbl.push_back(mk(1, 16'h0000, 32'h0024_0000, 0, 0, 0, 32'h8000_0015, 16'h0, 1));
    tbl.push_back(mk(1, 16'h0000, 32'h0024_0000, 0, 1, 0, 32'h8000_0015, 16'h0020, 1));
    tbl.push_back(mk(1, 16'h0000, 32'h0024_0000, 0, 0, 0, 32'h8000_0015, 16'h0, 0));
    // Masking: line 2 stays pending until enabled.
    tbl.push_back(mk(1, 16'h0004, 32'h0020_0000, 0, 0, 0, 32'h8000_0015, 16'h0, 0));
    tbl.push_back(mk(1, 16'h0004, 32'h0020_0000, 0, 0, 0, 32'h8000_0015, 16'h0, 0));
    tbl.push_back(mk(1, 16'h0000, 32'h0020_0000, 0, 0, 0, 32'h8000_0015, 16'h0, 0));
    tbl.push_back(mk(1, 16'h0000, 32'h0004_0000, 0, 0, 1, 32'h8000_0012, 16'h0, 1));
    tbl.push_back(mk(1, 16'h0000, 32'h0004_0000, 0, 0, 0, 32'h8000_0012, 16'h0, 1));
    tbl.push_back(mk(1, 16'h0000, 32'h0004_0000, 0, 1, 0, 32'h8000_0012, 16'h0004, 1));
    tbl.push_back(mk(1, 16'h0000, 32'h0004_0000, 0, 0, 0, 32'h8000_0012, 16'h0, 0));
    // Stall gating: line 3 waits, line 1 arrives mid-stall and wins.
    tbl.push_back(mk(1, 16'h0008, ALL, 1, 0, 0, 32'h8000_0012, 16'h0, 0));
    tbl.push_back(mk(1, 16'h0008, ALL, 1, 0, 0, 32'h8000_0012, 16'h0, 0));
    tbl.push_back(mk(1, 16'h000A, ALL, 1, 0, 0, 32'h8000_0012, 16'h0, 0));
    tbl.push_back(mk(1, 16'h000A, ALL, 1, 0, 0, 32'h8000_0012, 16'h0, 0));
    tbl.push_back(mk(1, 16'h000A, ALL, 0, 0, 1, 32'h8000_0011, 16'h0, 1));
    tbl.push_back(mk(1, 16'h000A, ALL, 0, 0, 0, 32'h8000_0011, 16'h0, 1));
    tbl.push_back(mk(1, 16'h0008, ALL, 0, 1, 0, 32'h8000_0011, 16'h0002, 1));
    tbl.push_back(mk(1, 16'h0008, ALL, 0, 0, 0, 32'h8000_0011, 16'h0, 0));
    tbl.push_back(mk(1, 16'h0008, ALL, 0, 0, 1, 32'h8000_0013, 16'h0, 1));
    tbl.push_back(mk(1, 16'h0008, ALL, 1, 0, 0, 32'h8000_0013, 16'h0, 1));
    tbl.push_back(mk(1, 16'h0000, ALL, 0, 1, 0, 32'h8000_0013, 16'h0008, 1));
    tbl.push_back(mk(1, 16'h0000, ALL, 0, 0, 0, 32'h8000_0013, 16'h0, 0));
    // Non-nesting: line 7 raised during SERVICE of line 4; mret in TRAP/RETURN ignored.
    tbl.push_back(mk(1, 16'h0010, ALL, 0, 0, 0, 32'h8000_0013, 16'h0, 0));
    tbl.push_back(mk(1, 16'h0010, ALL, 0, 0, 1, 32'h8000_0014, 16'h0, 1));
    tbl.push_back(mk(1, 16'h0090, ALL, 0, 0, 0, 32'h8000_0014, 16'h0, 1));
    tbl.push_back(mk(1, 16'h0090, ALL, 0, 0, 0, 32'h8000_0014, 16'h0, 1));
    tbl.push_back(mk(1, 16'h0080, ALL, 0, 1, 0, 32'h8000_0014, 16'h0010, 1));
    tbl.push_back(mk(1, 16'h0080, ALL, 0, 0, 0, 32'h8000_0014, 16'h0, 0));
    tbl.push_back(mk(1, 16'h0080, ALL, 0, 0, 1, 32'h8000_0017, 16'h0, 1));
    tbl.push_back(mk(1, 16'h0000, ALL, 0, 1, 0, 32'h8000_0017, 16'h0, 1));
    tbl.push_back(mk(1, 16'h0000, ALL, 0, 1, 0, 32'h8000_0017, 16'h0080, 1));
    tbl.push_back(mk(1, 16'h0000, ALL, 0, 1, 0, 32'h8000_0017, 16'h0, 0));

    foreach (tbl[i]) apply(tbl[i]);

    // Random-length stall on line 9: trap appears exactly when stall drops.
    begin
      logic [31:0] prev_mc;
      prev_mc = 32'h8000_0017;
      for (int rep = 0; rep < 4; rep++) begin
        int len;
        len = $urandom_range(1, 6);
        for (int i = 0; i < len; i++)
          apply(mk(1, 16'h0200, ALL, 1, 0, 0, prev_mc, 16'h0, 0));
        apply(mk(1, 16'h0200, ALL, 0, 0, 1, 32'h8000_0019, 16'h0, 1));
        apply(mk(1, 16'h0000, ALL, 0, 0, 0, 32'h8000_0019, 16'h0, 1));
        apply(mk(1, 16'h0000, ALL, 0, 1, 0, 32'h8000_0019, 16'h0200, 1));
        apply(mk(1, 16'h0000, ALL, 0, 0, 0, 32'h8000_0019, 16'h0, 0));
        prev_mc = 32'h8000_0019;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
